// File: rtl/count_slot_arbiter.sv
// Round-robin owner of a shared up-counter: grants timed slots of per-requester length,
// pulses done on completion or abort when the owner drops its request mid-slot.
module count_slot_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned CW   = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*CW-1:0]   len,
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      done,
   output logic                 abort,
   output logic                 busy,
   output logic [CW-1:0]        state,
   output logic                 phase
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

   fsm_e            fsm_q, fsm_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   len_q, len_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [NREQ-1:0] done_q, done_d;
   logic            abort_q, abort_d;
   logic            busy_q, busy_d;
   logic            phase_q, phase_d;

   logic            win_vld;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   scan_idx;
   logic            owner_req;
   logic            terminal;

   assign owner_req = req[ptr_q];
   assign terminal  = (cnt_q == len_q);

   // Round-robin scan starting just above the last owner, wrapping.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      scan_idx = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         scan_idx = PW'((32'(ptr_q) + i) % NREQ);
         if (!win_vld && req[scan_idx]) begin
            win_vld = 1'b1;
            win_idx = scan_idx;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fsm_q   <= StIdle;
         ptr_q   <= PW'(NREQ - 1);
         len_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         done_q  <= '0;
         abort_q <= 1'b0;
         busy_q  <= 1'b0;
         phase_q <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         abort_q <= abort_d;
         busy_q  <= busy_d;
         phase_q <= phase_d;
      end
   end

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         StIdle: if (win_vld) fsm_d = StRun;
         StRun: begin
            // Abort outranks terminal count.
            if (!owner_req)    fsm_d = StIdle;
            else if (terminal) fsm_d = StDone;
         end
         StDone:  fsm_d = StIdle;
         default: fsm_d = StIdle;
      endcase
   end

   always_comb begin
      ptr_d   = ptr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      done_d  = '0;
      abort_d = 1'b0;
      phase_d = phase_q;
      case (fsm_q)
         StIdle: begin
            if (win_vld) begin
               ptr_d   = win_idx;
               grant_d = NREQ'(1) << win_idx;
               cnt_d   = '0;
               for (int unsigned i = 0; i < NREQ; i++) begin
                  if (win_idx == PW'(i)) len_d = len[i*CW +: CW];
               end
            end
         end
         StRun: begin
            if (!owner_req) begin
               grant_d = '0;
               cnt_d   = '0;
               abort_d = 1'b1;
            end else if (terminal) begin
               cnt_d   = '0;
               done_d  = grant_q;
               phase_d = ~phase_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StDone:  grant_d = '0;
         default: grant_d = '0;
      endcase
      busy_d = (fsm_d != StIdle);
   end

   assign grant = grant_q;
   assign done  = done_q;
   assign abort = abort_q;
   assign busy  = busy_q;
   assign state = cnt_q;
   assign phase = phase_q;

endmodule

// File: tb/tb_count_slot_arbiter.sv
// Directed bench for count_slot_arbiter (NREQ=4, CW=3) with hand-computed expected outputs.
module tb_count_slot_arbiter;

   logic        clock;
   logic        reset;
   logic [3:0]  req;
   logic [11:0] len;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        abort;
   logic        busy;
   logic [2:0]  state;
   logic        phase;

   int checks   = 0;
   int failures = 0;
   logic ph = 1'b0;

   count_slot_arbiter #(.NREQ(4), .CW(3)) dut (
      .clock (clock),
      .reset (reset),
      .req   (req),
      .len   (len),
      .grant (grant),
      .done  (done),
      .abort (abort),
      .busy  (busy),
      .state (state),
      .phase (phase)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] d,
                             input logic a, input logic b, input logic [2:0] s,
                             input logic p);
      logic [13:0] obs;
      logic [13:0] exp;
      obs = {grant, done, abort, busy, state, phase};
      exp = {g, d, a, b, s, p};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed grant=%b done=%b abort=%b busy=%b state=%0d phase=%b, expected grant=%b done=%b abort=%b busy=%b state=%0d phase=%b",
                tag, grant, done, abort, busy, state, phase, g, d, a, b, s, p);
      end
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      len   = '0;
      step();
      step();
      expect_out("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0);
      reset = 1'b0;
      step();
      expect_out("idle_no_req", 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0);

      // Single slot, len0=2
      len = {3'd0, 3'd0, 3'd0, 3'd2};
      req = 4'b0001;
      step();
      expect_out("single_c1", 4'b0001, 4'b0000, 1'b0, 1'b1, 3'd0, ph);
      step();
      expect_out("single_c2", 4'b0001, 4'b0000, 1'b0, 1'b1, 3'd1, ph);
      step();
      expect_out("single_c3", 4'b0001, 4'b0000, 1'b0, 1'b1, 3'd2, ph);
      step();
      ph = ~ph;
      expect_out("single_done", 4'b0001, 4'b0001, 1'b0, 1'b1, 3'd0, ph);
      req = 4'b0000;
      step();
      expect_out("single_free", 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, ph);

      // Latched length: len0 changes to 6 mid-slot, slot still ends after 3 RUN cycles
      req = 4'b0001;
      step();
      expect_out("latch_grant", 4'b0001, 4'b0000, 1'b0, 1'b1, 3'd0, ph);
      len = {3'd0, 3'd0, 3'd0, 3'd6};
      step();
      expect_out("latch_s1", 4'b0001, 4'b0000, 1'b0, 1'b1, 3'd1, ph);
      step();
      expect_out("latch_s2", 4'b0001, 4'b0000, 1'b0, 1'b1, 3'd2, ph);
      step();
      ph = ~ph;
      expect_out("latch_done", 4'b0001, 4'b0001, 1'b0, 1'b1, 3'd0, ph);
      req = 4'b0000;
      step();
      expect_out("latch_free", 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, ph);

      // Abort: req[1] len=5, dropped while state=3
      len = {3'd0, 3'd0, 3'd5, 3'd0};
      req = 4'b0010;
      step();
      expect_out("abort_grant", 4'b0010, 4'b0000, 1'b0, 1'b1, 3'd0, ph);
      step();
      step();
      step();
      expect_out("abort_s3", 4'b0010, 4'b0000, 1'b0, 1'b1, 3'd3, ph);
      req = 4'b0000;
      step();
      expect_out("abort_pulse", 4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0, ph);
      // Pointer now 1: with req0 and req1 both up, req0 wins (scan 2,3,0).
      len = '0;
      req = 4'b0011;
      step();
      expect_out("abort_ptr", 4'b0001, 4'b0000, 1'b0, 1'b1, 3'd0, ph);
      step();
      ph = ~ph;
      expect_out("abort_next_done", 4'b0001, 4'b0001, 1'b0, 1'b1, 3'd0, ph);
      req = 4'b0000;
      step();
      expect_out("abort_next_free", 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, ph);

      // len=0 on req[2]: done one cycle after grant
      len = '0;
      req = 4'b0100;
      step();
      expect_out("len0_grant", 4'b0100, 4'b0000, 1'b0, 1'b1, 3'd0, ph);
      step();
      ph = ~ph;
      expect_out("len0_done", 4'b0100, 4'b0100, 1'b0, 1'b1, 3'd0, ph);
      req = 4'b0000;
      step();
      expect_out("len0_free", 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, ph);

      // len=7 on req[3]: counts 0..7 without wrapping
      len = {3'd7, 3'd0, 3'd0, 3'd0};
      req = 4'b1000;
      step();
      expect_out("len7_grant", 4'b1000, 4'b0000, 1'b0, 1'b1, 3'd0, ph);
      for (int k = 1; k <= 7; k++) begin
         step();
         expect_out($sformatf("len7_s%0d", k), 4'b1000, 4'b0000, 1'b0, 1'b1, 3'(k), ph);
      end
      step();
      ph = ~ph;
      expect_out("len7_done", 4'b1000, 4'b1000, 1'b0, 1'b1, 3'd0, ph);
      req = 4'b0000;
      step();
      expect_out("len7_free", 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, ph);

      // Reset mid-slot at state=4
      len = {3'd0, 3'd0, 3'd0, 3'd6};
      req = 4'b0001;
      step();
      expect_out("rst_grant", 4'b0001, 4'b0000, 1'b0, 1'b1, 3'd0, ph);
      step();
      step();
      step();
      step();
      expect_out("rst_s4", 4'b0001, 4'b0000, 1'b0, 1'b1, 3'd4, ph);
      reset = 1'b1;
      step();
      ph = 1'b0;
      expect_out("rst_mid", 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, ph);
      reset = 1'b0;

      // Round-robin with all requesting, len=0: 0001,0010,0100,1000,0001
      len = '0;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         logic [3:0] w;
         w = 4'b0001 << (k % 4);
         step();
         expect_out($sformatf("rr%0d_run", k), w, 4'b0000, 1'b0, 1'b1, 3'd0, ph);
         step();
         ph = ~ph;
         expect_out($sformatf("rr%0d_done", k), w, w, 1'b0, 1'b1, 3'd0, ph);
         step();
         expect_out($sformatf("rr%0d_idle", k), 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, ph);
      end
      req = 4'b0000;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
